dma_rd_src_engine: RTL and testbench

Parametrised read-source engine for the DMA AFU. It takes one descriptor at a time and splits it into AXI-MM read bursts, keeping up to MAX_OUTSTANDING bursts in flight. No burst crosses a 4 KB boundary. Read beats are tagged and pushed into the read-to-write data FIFO. Response errors are trapped into a sticky error state, and per-descriptor performance counters are kept.

---
 rtl/dma_rd_src_engine.sv | 230 +++++++++++++++++++++++
 tb/tb_dma_rd_src_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_src_engine.sv
// Read-source DMA engine: splits a descriptor into 4 KB-safe AXI read bursts, keeps up to MAX_OUTSTANDING in flight.
// Beats reach the FIFO one cycle after acceptance; r_ready drops combinationally on fifo_almost_full.
module dma_rd_src_engine #(
  parameter int DATA_W          = 512,
  parameter int ADDR_W          = 64,
  parameter int LEN_W           = 8,
  parameter int LENGTH_W        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int PERF_W          = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                desc_valid,
  output logic                desc_ready,
  input  logic [ADDR_W-1:0]   desc_src_addr,
  input  logic [LENGTH_W-1:0] desc_length,
  input  logic [1:0]          desc_burst,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [LEN_W-1:0]    ar_len,
  output logic [1:0]          ar_burst,
  output logic [2:0]          ar_size,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last,
  output logic                fifo_wr_en,
  output logic [DATA_W+1:0]   fifo_wr_data,
  input  logic                fifo_almost_full,
  input  logic                wr_done,
  input  logic                err_clr,
  output logic                busy,
  output logic                err,
  output logic [1:0]          err_code,
  output logic [31:0]         desc_count,
  output logic [PERF_W-1:0]   clk_cnt,
  output logic [PERF_W-1:0]   valid_cnt
);
  localparam int BYTES  = DATA_W / 8;
  localparam int SIZE_L = $clog2(BYTES);
  localparam int OW     = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW     = LENGTH_W + 14;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WAIT_WR, ERROR} state_t;

  state_t              state_q, state_d;
  logic                ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d, issue_addr_q, issue_addr_d;
  logic [LEN_W-1:0]    ar_len_q, ar_len_d;
  logic [1:0]          ar_burst_q, ar_burst_d;
  logic [LENGTH_W-1:0] remaining_q, remaining_d, len_q, len_d, rx_cnt_q, rx_cnt_d;
  logic                last_ar_q, last_ar_d, err_seen_q, err_seen_d;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_W+1:0]   fifo_wr_data_q, fifo_wr_data_d;
  logic                desc_ready_q, desc_ready_d, err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [31:0]         desc_count_q, desc_count_d;
  logic [PERF_W-1:0]   clk_cnt_q, clk_cnt_d, valid_cnt_q, valid_cnt_d;

  logic          r_acc, ar_hs, last_acc, pkt_last;
  logic [CW-1:0] rem_w, max_w, page_w, beats_w;

  assign r_ready  = (state_q inside {ISSUE, DRAIN, WAIT_WR}) && !fifo_almost_full;
  assign r_acc    = r_valid && r_ready;
  assign ar_hs    = ar_valid_q && ar_ready;
  assign last_acc = r_acc && r_last;
  assign pkt_last = (rx_cnt_q == len_q - LENGTH_W'(1));

  // Burst size is the smallest of: beats left, max AXI burst, beats to the next 4 KB page.
  always_comb begin
    rem_w   = CW'(remaining_q);
    max_w   = '0;
    max_w[LEN_W] = 1'b1;
    page_w  = CW'((13'h1000 - {1'b0, issue_addr_q[11:0]}) >> SIZE_L);
    beats_w = rem_w;
    if (max_w < beats_w) beats_w = max_w;
    if (page_w < beats_w) beats_w = page_w;
  end

  always_comb begin
    state_d        = state_q;
    ar_valid_d     = ar_valid_q && !ar_hs;
    ar_addr_d      = ar_addr_q;
    ar_len_d       = ar_len_q;
    ar_burst_d     = ar_burst_q;
    issue_addr_d   = issue_addr_q;
    remaining_d    = remaining_q;
    len_d          = len_q;
    rx_cnt_d       = rx_cnt_q;
    last_ar_d      = last_ar_q;
    err_seen_d     = err_seen_q || (r_acc && r_resp != 2'b00);
    outstanding_d  = outstanding_q + OW'(ar_hs) - OW'(last_acc);
    fifo_wr_en_d   = r_acc;
    fifo_wr_data_d = r_acc ? {pkt_last, r_last, r_data} : fifo_wr_data_q;
    desc_ready_d   = 1'b0;
    err_d          = err_q;
    err_code_d     = err_code_q;
    desc_count_d   = desc_count_q;
    clk_cnt_d      = (state_q != IDLE) ? clk_cnt_q + PERF_W'(1) : clk_cnt_q;
    valid_cnt_d    = r_acc ? valid_cnt_q + PERF_W'(1) : valid_cnt_q;
    if (r_acc) rx_cnt_d = rx_cnt_q + LENGTH_W'(1);

    case (state_q)
      IDLE: begin
        // desc_ready_q high means the popped descriptor is still visible this cycle.
        if (desc_valid && !desc_ready_q) begin
          if (desc_length == '0) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = 2'd1;
          end else begin
            state_d      = ISSUE;
            issue_addr_d = desc_src_addr;
            remaining_d  = desc_length;
            len_d        = desc_length;
            ar_burst_d   = desc_burst;
            rx_cnt_d     = '0;
            last_ar_d    = 1'b0;
            err_seen_d   = 1'b0;
            clk_cnt_d    = '0;
            valid_cnt_d  = '0;
          end
        end
      end
      ISSUE: begin
        if (!err_seen_d && !last_ar_q && (!ar_valid_q || ar_ready) &&
            outstanding_d < OW'(MAX_OUTSTANDING)) begin
          ar_valid_d   = 1'b1;
          ar_addr_d    = issue_addr_q;
          ar_len_d     = LEN_W'(beats_w - CW'(1));
          issue_addr_d = issue_addr_q + (ADDR_W'(beats_w) << SIZE_L);
          remaining_d  = remaining_q - beats_w[LENGTH_W-1:0];
          last_ar_d    = (rem_w == beats_w);
        end
        if ((ar_hs && last_ar_q) || (err_seen_d && (!ar_valid_q || ar_ready)))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (outstanding_q == '0) begin
          if (err_seen_q) begin
            state_d    = ERROR;
            err_d      = 1'b1;
            err_code_d = 2'd2;
          end else begin
            state_d = WAIT_WR;
          end
        end
      end
      WAIT_WR: begin
        if (wr_done) begin
          state_d      = IDLE;
          desc_ready_d = 1'b1;
          desc_count_d = desc_count_q + 32'd1;
        end
      end
      ERROR: begin
        if (err_clr) begin
          state_d    = IDLE;
          err_d      = 1'b0;
          err_code_d = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ar_valid_q     <= 1'b0;
      ar_addr_q      <= '0;
      ar_len_q       <= '0;
      ar_burst_q     <= '0;
      issue_addr_q   <= '0;
      remaining_q    <= '0;
      len_q          <= '0;
      rx_cnt_q       <= '0;
      last_ar_q      <= 1'b0;
      err_seen_q     <= 1'b0;
      outstanding_q  <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_wr_data_q <= '0;
      desc_ready_q   <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= '0;
      desc_count_q   <= '0;
      clk_cnt_q      <= '0;
      valid_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      ar_valid_q     <= ar_valid_d;
      ar_addr_q      <= ar_addr_d;
      ar_len_q       <= ar_len_d;
      ar_burst_q     <= ar_burst_d;
      issue_addr_q   <= issue_addr_d;
      remaining_q    <= remaining_d;
      len_q          <= len_d;
      rx_cnt_q       <= rx_cnt_d;
      last_ar_q      <= last_ar_d;
      err_seen_q     <= err_seen_d;
      outstanding_q  <= outstanding_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_wr_data_q <= fifo_wr_data_d;
      desc_ready_q   <= desc_ready_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      desc_count_q   <= desc_count_d;
      clk_cnt_q      <= clk_cnt_d;
      valid_cnt_q    <= valid_cnt_d;
    end
  end

  assign desc_ready   = desc_ready_q;
  assign ar_valid     = ar_valid_q;
  assign ar_addr      = ar_addr_q;
  assign ar_len       = ar_len_q;
  assign ar_burst     = ar_burst_q;
  assign ar_size      = 3'(SIZE_L);
  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_wr_data = fifo_wr_data_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign desc_count   = desc_count_q;
  assign clk_cnt      = clk_cnt_q;
  assign valid_cnt    = valid_cnt_q;
endmodule

// File: tb/tb_dma_rd_src_engine.sv
// Bench for dma_rd_src_engine: descriptor table plus hand-written sequences for backpressure, errors and reset.
module tb_dma_rd_src_engine;
  localparam int DATA_W = 512, ADDR_W = 32, LEN_W = 4, LENGTH_W = 32, MAX_OUT = 2, PERF_W = 32;

  logic clk = 1'b0, reset = 1'b1;
  logic desc_valid, desc_ready;
  logic [ADDR_W-1:0] desc_src_addr;
  logic [LENGTH_W-1:0] desc_length;
  logic [1:0] desc_burst;
  logic ar_valid, ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [LEN_W-1:0] ar_len;
  logic [1:0] ar_burst;
  logic [2:0] ar_size;
  logic r_valid, r_ready, r_last;
  logic [DATA_W-1:0] r_data;
  logic [1:0] r_resp;
  logic fifo_wr_en, fifo_almost_full, wr_done, err_clr, busy, err;
  logic [DATA_W+1:0] fifo_wr_data;
  logic [1:0] err_code;
  logic [31:0] desc_count;
  logic [PERF_W-1:0] clk_cnt, valid_cnt;

  dma_rd_src_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .LENGTH_W(LENGTH_W),
                      .MAX_OUTSTANDING(MAX_OUT), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_src_addr(desc_src_addr), .desc_length(desc_length), .desc_burst(desc_burst),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_burst(ar_burst), .ar_size(ar_size), .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .fifo_almost_full(fifo_almost_full), .wr_done(wr_done),
    .err_clr(err_clr), .busy(busy), .err(err), .err_code(err_code), .desc_count(desc_count),
    .clk_cnt(clk_cnt), .valid_cnt(valid_cnt));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Slave/monitor state
  bit r_en, ar_rdy_en, ar_rdy_on_last, sim_flag;
  int err_beat = -1;
  int beat_idx, wr_cnt, pkt_n, last_pos, ready_pulses, cyc, first_last_cyc, ar3_cyc;
  int out_model, out_max, sim_n;
  logic [31:0] ar_addr_log[$];
  int ar_len_log[$];
  int burst_rem[$];

  initial begin
    bit have, hs_ar, hs_r, lst;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'd0; r_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        burst_rem.delete(); out_model = 0; sim_flag = 0;
        r_valid = 1'b0; r_last = 1'b0; ar_ready = 1'b0;
        continue;
      end
      if (sim_flag) begin
        chk("outstanding_after_simul_ar_rlast", longint'(dut.outstanding_q), out_model);
        sim_flag = 0;
      end
      if (fifo_wr_en) begin
        chk("wr_data_seq", fifo_wr_data[31:0], wr_cnt);
        wr_cnt++;
        if (fifo_wr_data[DATA_W+1]) begin pkt_n++; last_pos = wr_cnt; end
      end
      if (desc_ready) ready_pulses++;
      have = r_en && (burst_rem.size() > 0);
      r_valid = have;
      r_last = have ? (burst_rem[0] == 1) : 1'b0;
      r_data = DATA_W'(beat_idx);
      r_resp = (have && beat_idx == err_beat) ? 2'd2 : 2'd0;
      ar_ready = ar_rdy_en || (ar_rdy_on_last && r_last);
      #3;
      hs_ar = ar_valid && ar_ready;
      hs_r = r_valid && r_ready;
      lst = hs_r && r_last;
      if (hs_r) begin
        beat_idx++;
        burst_rem[0] = burst_rem[0] - 1;
        if (lst) begin
          void'(burst_rem.pop_front());
          if (first_last_cyc < 0) first_last_cyc = cyc;
        end
      end
      if (hs_ar) begin
        ar_addr_log.push_back(ar_addr);
        ar_len_log.push_back(int'(ar_len));
        burst_rem.push_back(int'(ar_len) + 1);
        if (ar_addr_log.size() == 3) ar3_cyc = cyc;
      end
      out_model = out_model + int'(hs_ar) - int'(lst);
      if (out_model > out_max) out_max = out_model;
      if (hs_ar && lst) begin sim_flag = 1; sim_n++; end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic start_desc(input logic [31:0] addr, input int len);
    tick();
    ar_addr_log.delete(); ar_len_log.delete();
    wr_cnt = 0; beat_idx = 0; pkt_n = 0; last_pos = 0; ready_pulses = 0;
    first_last_cyc = -1; ar3_cyc = -1; sim_n = 0;
    desc_src_addr = addr; desc_length = LENGTH_W'(len); desc_burst = 2'd1;
    desc_valid = 1'b1;
  endtask

  task automatic wait_wr(input int n);
    int k = 0;
    while (wr_cnt < n && k < 3000) begin tick(); k++; end
    chk("wait_writes_reached", wr_cnt >= n, 1);
  endtask

  int exp_desc_count = 0;
  task automatic finish_desc(input int len, input int n_ar);
    wait_wr(len);
    repeat (3) tick();
    chk("busy_in_wait_wr", busy, 1);
    chk("no_ready_before_wr_done", ready_pulses, 0);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    desc_valid = 1'b0;
    repeat (3) tick();
    exp_desc_count++;
    chk("wr_count", wr_cnt, len);
    chk("pkt_last_count", pkt_n, 1);
    chk("pkt_last_position", last_pos, len);
    chk("desc_ready_pulses", ready_pulses, 1);
    chk("desc_count", desc_count, exp_desc_count);
    chk("valid_cnt", valid_cnt, len);
    chk("busy_after_done", busy, 0);
    chk("ar_count", ar_addr_log.size(), n_ar);
  endtask

  typedef struct {
    logic [31:0] addr;
    int len;
    int n_ar;
    logic [31:0] a0; int l0;
    logic [31:0] a1; int l1;
    logic [31:0] a2; int l2;
  } vec_t;
  vec_t vt[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea[3];
    int el[3];
    vt[0] = '{32'h1000, 40, 3, 32'h1000, 15, 32'h1400, 15, 32'h1800, 7};
    vt[1] = '{32'h1F80, 16, 2, 32'h1F80, 1, 32'h2000, 13, 32'h0, 0};
    vt[2] = '{32'h0040, 1, 1, 32'h0040, 0, 32'h0, 0, 32'h0, 0};
    vt[3] = '{32'h3FC0, 3, 2, 32'h3FC0, 0, 32'h4000, 1, 32'h0, 0};
    vt[4] = '{32'h2C00, 20, 2, 32'h2C00, 15, 32'h3000, 3, 32'h0, 0};

    desc_valid = 1'b0; desc_src_addr = '0; desc_length = '0; desc_burst = 2'd0;
    fifo_almost_full = 1'b0; wr_done = 1'b0; err_clr = 1'b0;
    r_en = 1; ar_rdy_en = 1; ar_rdy_on_last = 0;
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_ar_valid", ar_valid, 0);
    chk("rst_ar_size", ar_size, 6);
    chk("rst_ar_addr", ar_addr, 0);
    chk("rst_r_ready", r_ready, 0);
    chk("rst_fifo_wr_en", fifo_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_desc_count", desc_count, 0);
    chk("rst_desc_ready", desc_ready, 0);
    reset = 1'b0;
    tick();

    // Table of descriptors with hand-computed AR splits
    for (int i = 0; i < 5; i++) begin
      ea[0] = vt[i].a0; ea[1] = vt[i].a1; ea[2] = vt[i].a2;
      el[0] = vt[i].l0; el[1] = vt[i].l1; el[2] = vt[i].l2;
      start_desc(vt[i].addr, vt[i].len);
      finish_desc(vt[i].len, vt[i].n_ar);
      for (int j = 0; j < vt[i].n_ar; j++) begin
        chk($sformatf("v%0d_ar%0d_addr", i, j),
            (j < ar_addr_log.size()) ? longint'(ar_addr_log[j]) : -1, ea[j]);
        chk($sformatf("v%0d_ar%0d_len", i, j),
            (j < ar_len_log.size()) ? longint'(ar_len_log[j]) : -1, el[j]);
      end
    end

    // Outstanding limit: no read data, only MAX_OUT bursts may be issued
    r_en = 0;
    start_desc(32'h8000, 64);
    repeat (20) tick();
    chk("stall_ar_count", ar_addr_log.size(), 2);
    r_en = 1;
    for (int k = 0; k < 200 && ar_addr_log.size() < 3; k++) tick();
    chk("third_ar_issued", ar_addr_log.size(), 3);
    chk("third_ar_within_2_cycles", (ar3_cyc - first_last_cyc) inside {[1:2]}, 1);
    ar_rdy_en = 0; ar_rdy_on_last = 1;
    for (int k = 0; k < 200 && sim_n < 1; k++) tick();
    chk("simultaneous_ar_rlast_seen", sim_n >= 1, 1);
    tick();
    ar_rdy_en = 1; ar_rdy_on_last = 0;
    finish_desc(64, 4);

    // Almost-full window mid-burst
    start_desc(32'h0, 40);
    wait_wr(5);
    fifo_almost_full = 1'b1;
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("af_r_ready_low", r_ready, 0);
      chk("af_no_fifo_wr", fifo_wr_en, 0);
    end
    tick();
    chk("af_last_cycle_no_fifo_wr", fifo_wr_en, 0);
    fifo_almost_full = 1'b0;
    finish_desc(40, 3);

    // Bad response on beat 5 of a 64-beat descriptor
    err_beat = 4;
    start_desc(32'h0, 64);
    for (int k = 0; k < 500 && !err; k++) tick();
    chk("resp_err_flag", err, 1);
    chk("resp_err_code", err_code, 2);
    chk("resp_err_ar_count", ar_addr_log.size(), 2);
    chk("resp_err_drained_writes", wr_cnt, 32);
    chk("resp_err_valid_cnt", valid_cnt, 32);
    chk("resp_err_no_desc_ready", ready_pulses, 0);
    chk("resp_err_no_pkt_last", pkt_n, 0);
    chk("resp_err_busy", busy, 1);
    desc_valid = 1'b0; err_beat = -1;
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    chk("resp_err_cleared", err, 0);
    chk("resp_err_code_cleared", err_code, 0);
    chk("resp_err_idle", busy, 0);

    // Zero-length descriptor
    start_desc(32'h100, 0);
    repeat (4) tick();
    chk("zero_len_err", err, 1);
    chk("zero_len_code", err_code, 1);
    chk("zero_len_no_ar", ar_addr_log.size(), 0);
    chk("zero_len_busy", busy, 1);
    desc_valid = 1'b0;
    err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    chk("zero_len_cleared", err, 0);
    chk("zero_len_idle", busy, 0);

    // Reset in the middle of a burst
    start_desc(32'h1000, 40);
    wait_wr(8);
    reset = 1'b1;
    #1;
    chk("midrst_ar_valid", ar_valid, 0);
    chk("midrst_ar_len", ar_len, 0);
    chk("midrst_r_ready", r_ready, 0);
    chk("midrst_fifo_wr_en", fifo_wr_en, 0);
    chk("midrst_fifo_wr_data", fifo_wr_data[31:0], 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_desc_count", desc_count, 0);
    chk("midrst_clk_cnt", clk_cnt, 0);
    chk("midrst_valid_cnt", valid_cnt, 0);
    chk("midrst_ar_size", ar_size, 6);
    desc_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    chk("post_rst_idle", busy, 0);
    chk("outstanding_never_above_max", out_max <= MAX_OUT, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
